// File: rtl/ahb_master_dma.sv
// rtl/ahb_master_dma.sv - AHB-Lite master streaming 128-bit blocks from memory through AES and back
module ahb_master_dma #(
    parameter int WORDS_PER_BLK = 4
) (
    input  logic         hclk,
    input  logic         hreset,
    input  logic         start,
    input  logic [31:0]  src_addr,
    input  logic [31:0]  dst_addr,
    input  logic [31:0]  size_data,
    output logic [31:0]  haddr,
    output logic [1:0]   htrans,
    output logic         hwrite,
    output logic [2:0]   hsize,
    output logic [2:0]   hburst,
    output logic [31:0]  hwdata,
    input  logic [31:0]  hrdata,
    input  logic         hready,
    input  logic         hresp,
    output logic [127:0] blk_out,
    output logic         blk_out_valid,
    input  logic         blk_out_ready,
    input  logic [127:0] blk_in,
    input  logic         blk_in_valid,
    output logic         blk_in_ready,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] LAST_WORD    = 2'(WORDS_PER_BLK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_SEND,
        S_RECV,
        S_WR_ADDR,
        S_WR_DATA,
        S_FINISH
    } state_t;

    state_t       state;
    logic [31:0]  src_ptr;
    logic [31:0]  dst_ptr;
    logic [27:0]  blk_cnt;
    logic [1:0]   widx;
    logic [127:0] res_buf;
    logic [31:0]  next_off;
    logic         unused_low_bits;

    // Byte offset of the next word within the current block (wraps with widx)
    assign next_off = {28'd0, widx + 2'd1, 2'b00};

    // Only single word transfers are ever issued
    assign hsize  = 3'b010;
    assign hburst = 3'b000;

    // Sub-word address bits and sub-block length bits carry no meaning here
    assign unused_low_bits = ^{src_addr[1:0], dst_addr[1:0], size_data[3:0]};

    // Job sequencer: every bus and handshake output is registered on the transition into its state
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state         <= S_IDLE;
            haddr         <= 32'd0;
            htrans        <= TRANS_IDLE;
            hwrite        <= 1'b0;
            hwdata        <= 32'd0;
            blk_out       <= 128'd0;
            blk_out_valid <= 1'b0;
            blk_in_ready  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            src_ptr       <= 32'd0;
            dst_ptr       <= 32'd0;
            blk_cnt       <= 28'd0;
            widx          <= 2'd0;
            res_buf       <= 128'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr <= {src_addr[31:2], 2'b00};
                        dst_ptr <= {dst_addr[31:2], 2'b00};
                        blk_cnt <= size_data[31:4];
                        widx    <= 2'd0;
                        error   <= 1'b0;
                        if (size_data[31:4] == 28'd0) begin
                            // Empty job: report completion without touching the bus
                            state <= S_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state  <= S_RD_ADDR;
                            busy   <= 1'b1;
                            htrans <= TRANS_NONSEQ;
                            hwrite <= 1'b0;
                            haddr  <= {src_addr[31:2], 2'b00};
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (hready) begin
                        state  <= S_RD_DATA;
                        htrans <= TRANS_IDLE;
                    end
                end
                S_RD_DATA: begin
                    if (hresp) begin
                        // First ERROR cycle: drop the job, bus is already IDLE for the second cycle
                        error <= 1'b1;
                        state <= S_FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (hready) begin
                        // Shift words in so the first word read ends up in [127:96]
                        blk_out <= {blk_out[95:0], hrdata};
                        if (widx == LAST_WORD) begin
                            widx          <= 2'd0;
                            state         <= S_SEND;
                            blk_out_valid <= 1'b1;
                        end else begin
                            widx   <= widx + 2'd1;
                            state  <= S_RD_ADDR;
                            htrans <= TRANS_NONSEQ;
                            haddr  <= src_ptr + next_off;
                        end
                    end
                end
                S_SEND: begin
                    if (blk_out_ready) begin
                        blk_out_valid <= 1'b0;
                        blk_in_ready  <= 1'b1;
                        state         <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (blk_in_valid) begin
                        blk_in_ready <= 1'b0;
                        res_buf      <= blk_in;
                        state        <= S_WR_ADDR;
                        htrans       <= TRANS_NONSEQ;
                        hwrite       <= 1'b1;
                        haddr        <= dst_ptr;
                    end
                end
                S_WR_ADDR: begin
                    if (hready) begin
                        state   <= S_WR_DATA;
                        htrans  <= TRANS_IDLE;
                        hwdata  <= res_buf[127:96];
                        res_buf <= {res_buf[95:0], 32'd0};
                    end
                end
                S_WR_DATA: begin
                    if (hresp) begin
                        error  <= 1'b1;
                        state  <= S_FINISH;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        hwrite <= 1'b0;
                    end else if (hready) begin
                        if (widx != LAST_WORD) begin
                            widx   <= widx + 2'd1;
                            state  <= S_WR_ADDR;
                            htrans <= TRANS_NONSEQ;
                            haddr  <= dst_ptr + next_off;
                        end else begin
                            widx    <= 2'd0;
                            src_ptr <= src_ptr + 32'd16;
                            dst_ptr <= dst_ptr + 32'd16;
                            blk_cnt <= blk_cnt - 28'd1;
                            hwrite  <= 1'b0;
                            if (blk_cnt == 28'd1) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state  <= S_RD_ADDR;
                                htrans <= TRANS_NONSEQ;
                                haddr  <= src_ptr + 32'd16;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    // done was raised on entry; a start seen here is deliberately ignored
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_dma.sv
// tb/tb_ahb_master_dma.sv - scoreboard bench for ahb_master_dma with memory slave and AES models
module tb_ahb_master_dma;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct packed {
        bit chk_cyc;
        int cyc;
        bit err;
    } done_t;

    logic         hclk = 1'b0;
    logic         hreset;
    logic         start;
    logic [31:0]  src_addr, dst_addr, size_data;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize, hburst;
    logic [31:0]  hwdata, hrdata;
    logic         hready, hresp;
    logic [127:0] blk_out, blk_in;
    logic         blk_out_valid, blk_out_ready, blk_in_valid, blk_in_ready;
    logic         busy, done, error;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_seen = 0;
    int wait_n = 0;
    int err_rd = -1;
    int rd_num = 0;
    bit aes_en = 1'b1;

    xfer_t        exp_x[$];
    logic [127:0] exp_b[$];
    done_t        exp_d[$];

    ahb_master_dma #(.WORDS_PER_BLK(4)) dut (
        .hclk(hclk), .hreset(hreset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .size_data(size_data),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .blk_out(blk_out), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
        .blk_in(blk_in), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 hclk = ~hclk;

    initial forever begin
        @(posedge hclk);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [127:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected no such event", name, act);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h00112233;
            32'h104: return 32'h44556677;
            32'h108: return 32'h8899AABB;
            32'h10C: return 32'hCCDDEEFF;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_haddr"}, 128'(haddr), 128'(0));
        chk({tag, "_htrans"}, 128'(htrans), 128'(T_IDLE));
        chk({tag, "_hwrite"}, 128'(hwrite), 128'(0));
        chk({tag, "_hwdata"}, 128'(hwdata), 128'(0));
        chk({tag, "_hsize"}, 128'(hsize), 128'(3'b010));
        chk({tag, "_hburst"}, 128'(hburst), 128'(3'b000));
        chk({tag, "_blk_out"}, blk_out, 128'(0));
        chk({tag, "_blk_out_valid"}, 128'(blk_out_valid), 128'(0));
        chk({tag, "_blk_in_ready"}, 128'(blk_in_ready), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_error"}, 128'(error), 128'(0));
    endtask

    // Push every expected transfer, block and done for a job, then pulse start
    task automatic issue(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size,
                         input int waits, input int erri);
        int nblk;
        logic [127:0] blk;
        xfer_t x;
        done_t d;
        nblk = int'(size[31:4]);
        wait_n = waits;
        err_rd = erri;
        rd_num = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 4; w++) begin
                if (erri < 0 || b * 4 + w <= erri) begin
                    x.wr = 1'b0;
                    x.addr = src + 32'(16 * b + 4 * w);
                    x.data = 32'd0;
                    exp_x.push_back(x);
                end
            end
            if (erri < 0) begin
                blk = {mem_word(src + 32'(16 * b)), mem_word(src + 32'(16 * b + 4)),
                       mem_word(src + 32'(16 * b + 8)), mem_word(src + 32'(16 * b + 12))};
                exp_b.push_back(blk);
                for (int w = 0; w < 4; w++) begin
                    x.wr = 1'b1;
                    x.addr = dst + 32'(16 * b + 4 * w);
                    x.data = ~blk[127 - 32 * w -: 32];
                    exp_x.push_back(x);
                end
            end
        end
        @(negedge hclk);
        src_addr = src;
        dst_addr = dst;
        size_data = size;
        start = 1'b1;
        d.chk_cyc = (waits == 0 && erri < 0);
        d.cyc = cyc + 18 * nblk + 1;
        d.err = (erri >= 0);
        exp_d.push_back(d);
        @(negedge hclk);
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(nblk != 0));
        chk("error_cleared_by_start", 128'(error), 128'(0));
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (exp_d.size() != 0 && t < 3000) begin
            @(negedge hclk);
            t++;
        end
        if (exp_d.size() != 0) begin
            fail_now({tag, "_done_timeout"}, 128'(t));
            exp_d.delete();
        end
        @(negedge hclk);
        chk({tag, "_xfers_left"}, 128'(exp_x.size()), 128'(0));
        chk({tag, "_blks_left"}, 128'(exp_b.size()), 128'(0));
        exp_x.delete();
        exp_b.delete();
    endtask

    // AHB memory slave with programmable wait states and one injectable read ERROR
    initial begin : slave
        logic        dphase, d_wr, d_err, p_valid, p_hwrite;
        logic [31:0] d_exp, d_addr, p_haddr, p_hwdata;
        logic [1:0]  p_htrans;
        int          cnt, err_stage;
        xfer_t       x;
        dphase = 1'b0; d_wr = 1'b0; d_err = 1'b0; p_valid = 1'b0; p_hwrite = 1'b0;
        d_exp = 32'd0; d_addr = 32'd0; p_haddr = 32'd0; p_hwdata = 32'd0; p_htrans = T_IDLE;
        cnt = 0; err_stage = 0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                dphase = 1'b0; p_valid = 1'b0; cnt = 0; err_stage = 0;
                hready = 1'b1; hresp = 1'b0;
            end else begin
                if (p_valid) begin
                    if (dphase && hready) begin
                        if (d_wr && !d_err) chk("hwdata", 128'(p_hwdata), 128'(d_exp));
                        dphase = 1'b0; cnt = 0; err_stage = 0;
                    end else if (dphase && d_wr) begin
                        chk("hwdata_stable", 128'(hwdata), 128'(p_hwdata));
                    end
                    if (p_htrans == T_NONSEQ) begin
                        if (hready) begin
                            if (exp_x.size() == 0) begin
                                fail_now("unexpected_xfer", 128'(p_haddr));
                                d_exp = 32'd0;
                            end else begin
                                x = exp_x.pop_front();
                                chk("xfer_hwrite", 128'(p_hwrite), 128'(x.wr));
                                chk("xfer_haddr", 128'(p_haddr), 128'(x.addr));
                                d_exp = x.data;
                            end
                            dphase = 1'b1; d_wr = p_hwrite; d_addr = p_haddr; cnt = 0;
                            d_err = !p_hwrite && (rd_num == err_rd);
                            if (!p_hwrite) rd_num++;
                        end else begin
                            chk("htrans_stable", 128'(htrans), 128'(p_htrans));
                            chk("haddr_stable", 128'(haddr), 128'(p_haddr));
                            chk("hwrite_stable", 128'(hwrite), 128'(p_hwrite));
                        end
                    end
                end
                hresp = 1'b0;
                if (dphase) begin
                    if (d_err) begin
                        hresp = 1'b1;
                        if (err_stage == 0) begin
                            hready = 1'b0;
                            err_stage = 1;
                        end else begin
                            hready = 1'b1;
                            chk("htrans_idle_2nd_error_cycle", 128'(htrans), 128'(T_IDLE));
                        end
                    end else if (cnt < wait_n) begin
                        hready = 1'b0;
                        cnt++;
                    end else begin
                        hready = 1'b1;
                        if (!d_wr) hrdata = mem_word(d_addr);
                    end
                end else if (htrans == T_NONSEQ) begin
                    if (cnt < wait_n) begin
                        hready = 1'b0;
                        cnt++;
                    end else begin
                        hready = 1'b1;
                    end
                end else begin
                    hready = 1'b1;
                    cnt = 0;
                end
                p_htrans = htrans; p_haddr = haddr; p_hwrite = hwrite; p_hwdata = hwdata;
                p_valid = 1'b1;
            end
        end
    end

    // AES model: checks each offered block and answers with its bitwise inverse
    initial begin : aes
        logic [127:0] aes_res;
        aes_res = 128'd0;
        blk_out_ready = 1'b0; blk_in_valid = 1'b0; blk_in = 128'd0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                blk_out_ready = 1'b0;
                blk_in_valid = 1'b0;
            end else begin
                blk_out_ready = 1'b1;
                if (blk_out_valid) begin
                    if (exp_b.size() == 0) fail_now("unexpected_blk_out", blk_out);
                    else chk("blk_out", blk_out, exp_b.pop_front());
                    aes_res = ~blk_out;
                end
                blk_in = aes_res;
                blk_in_valid = blk_in_ready && aes_en;
            end
        end
    end

    // Completion monitor
    initial begin : done_mon
        done_t e;
        forever begin
            @(negedge hclk);
            if (done === 1'b1) begin
                done_seen++;
                if (exp_d.size() == 0) begin
                    fail_now("unexpected_done", 128'(cyc));
                end else begin
                    e = exp_d.pop_front();
                    if (e.chk_cyc) chk("done_cycle", 128'(cyc), 128'(e.cyc));
                    chk("error_at_done", 128'(error), 128'(e.err));
                    chk("busy_at_done", 128'(busy), 128'(0));
                end
            end
        end
    end

    initial begin : stim
        int base;
        int t;
        hreset = 1'b1; start = 1'b0;
        src_addr = 32'd0; dst_addr = 32'd0; size_data = 32'd0;
        repeat (3) @(negedge hclk);
        chk_reset("por");
        hreset = 1'b0;
        repeat (2) @(negedge hclk);

        // single block, zero wait states, done 19 cycles after start
        issue(32'h100, 32'h200, 32'h10, 0, -1);
        wait_done("single");

        // three blocks with a start while busy that must be ignored
        base = done_seen;
        issue(32'h100, 32'h200, 32'h3F, 0, -1);
        repeat (5) @(negedge hclk);
        src_addr = 32'h900; dst_addr = 32'hA00; size_data = 32'h100; start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        wait_done("three");
        chk("three_done_count", 128'(done_seen - base), 128'(1));

        // three wait states on every phase
        issue(32'h300, 32'h400, 32'h20, 3, -1);
        wait_done("waits");

        // ERROR on third read, then a fresh start clears the flag
        issue(32'h100, 32'h200, 32'h10, 0, 2);
        wait_done("err");
        chk("error_sticky", 128'(error), 128'(1));
        issue(32'h500, 32'h600, 32'h10, 0, -1);
        wait_done("after_err");

        // zero-block job
        issue(32'h100, 32'h200, 32'h0F, 0, -1);
        wait_done("empty");

        // start in the done cycle is dropped
        issue(32'h100, 32'h200, 32'h10, 0, -1);
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge hclk);
            t++;
        end
        if (t >= 100) fail_now("wait_done_timeout", 128'(t));
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        chk("start_at_done_dropped", 128'(busy), 128'(0));
        wait_done("drop");

        // reset while waiting in RECV
        aes_en = 1'b0;
        issue(32'h100, 32'h200, 32'h10, 0, -1);
        t = 0;
        while (blk_in_ready !== 1'b1 && t < 100) begin
            @(negedge hclk);
            t++;
        end
        if (t >= 100) fail_now("recv_timeout", 128'(t));
        #2 hreset = 1'b1;
        #1 chk_reset("rst_recv");
        exp_x.delete(); exp_b.delete(); exp_d.delete();
        base = done_seen;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        aes_en = 1'b1;
        repeat (30) @(negedge hclk);
        chk("no_done_after_reset", 128'(done_seen), 128'(base));
        chk("idle_after_reset", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_master_dma.md
# ahb_master_dma

AHB-Lite bus master that moves data through the AES core, driven by the configuration block's register outputs. On `start` it reads 128-bit blocks as 4 words from `src_addr`, hands each block to the AES datapath and accepts the result. It then writes the result as 4 words to `dst_addr`, repeating until `size_data` bytes are processed. It is the initiator counterpart of the register-mapped AHB slave: the slave receives configuration from the CPU, and this block issues the memory traffic.

## Interface
Parameters:
- `WORDS_PER_BLK`, 4: 32-bit words per AES block. Fixed at 4; other values unsupported.

Ports:
- `hclk`  in  1  bus clock. The only clock.
- `hreset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that launches a job. Ignored while `busy`=1.
- `src_addr`  in  32  read base address (byte). Bits [1:0] are ignored.
- `dst_addr`  in  32  write base address (byte). Bits [1:0] are ignored.
- `size_data`  in  32  job length in bytes. Blocks = `size_data[31:4]`. Bits [3:0] are ignored.
- `haddr`  out  32  AHB address.
- `htrans`  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- `hwrite`  out  1  1 = write.
- `hsize`  out  3  constant 3'b010 (word).
- `hburst`  out  3  constant 3'b000 (SINGLE).
- `hwdata`  out  32  write data.
- `hrdata`  in  32  read data.
- `hready`  in  1  bus ready.
- `hresp`  in  1  1 = ERROR.
- `blk_out`  out  128  block sent to AES. The first word read occupies [127:96].
- `blk_out_valid`  out  1  high while waiting for `blk_out_ready`.
- `blk_out_ready`  in  1  AES accepts the block.
- `blk_in`  in  128  AES result.
- `blk_in_valid`  in  1  result valid.
- `blk_in_ready`  out  1  high while waiting for `blk_in_valid`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse at job end.
- `error`  out  1  sticky error flag. Cleared by the next accepted `start`.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, SEND, RECV, WR_ADDR, WR_DATA, FINISH.
- IDLE to RD_ADDR on `start`:
  - Latch `src_ptr`, `dst_ptr` and `blk_cnt`.
  - Clear `error`. Set `busy`=1.
  - If `blk_cnt`=0, go directly to FINISH instead.
- RD_ADDR:
  - Drive `htrans`=NONSEQ, `hwrite`=0, `haddr`=`src_ptr`+4*`widx`.
  - Move to RD_DATA when `hready`=1. Otherwise hold with all signals stable.
- RD_DATA:
  - Drive `htrans`=IDLE.
  - When `hready`=1, store `hrdata` into word `widx`.
  - If `widx`=3, clear `widx` and go to SEND. Otherwise increment `widx` and return to RD_ADDR.
- SEND:
  - Drive `blk_out_valid`=1; `blk_out` is stable.
  - On `blk_out_ready`=1, go to RECV.
- RECV:
  - Drive `blk_in_ready`=1.
  - On `blk_in_valid`=1, capture `blk_in` and go to WR_ADDR.
- WR_ADDR:
  - Drive `htrans`=NONSEQ, `hwrite`=1, `haddr`=`dst_ptr`+4*`widx`.
  - Move to WR_DATA on `hready`=1.
- WR_DATA:
  - Drive `htrans`=IDLE. Drive `hwdata` = result word `widx`, where word 0 = [127:96].
  - On `hready`=1, if `widx`<3, increment `widx` and return to WR_ADDR.
  - If `widx`=3:
    - Add 16 to `src_ptr` and `dst_ptr`, and decrement `blk_cnt`.
    - Go to FINISH if `blk_cnt` becomes 0, else go to RD_ADDR.
- FINISH: pulse `done`=1, set `busy`=0, return to IDLE.
- ERROR response: `hresp`=1 in RD_DATA or WR_DATA (on the first ERROR cycle, with `hready`=0):
  - Set `error`=1 and abandon the job. The partial block is not written.
  - Go to FINISH, so `done` pulses with `error`=1.
  - `htrans` is IDLE on the second ERROR cycle, as AHB-Lite requires.
- Address arithmetic is 32-bit modulo and wraps silently at 0xFFFF_FFFC. `blk_cnt` is 28 bits.

## Timing
- Reset values (applied asynchronously while `hreset`=1):
  - `htrans`=IDLE, `haddr`=0, `hwrite`=0, `hwdata`=0.
  - `blk_out`=0, `blk_out_valid`=0, `blk_in_ready`=0.
  - `busy`=0, `done`=0, `error`=0.
  - State = IDLE. All pointers and counters = 0.
- Reset mid-job aborts immediately: no `done` pulse, and bus outputs go IDLE in the same cycle.
- With zero wait states, each word takes 2 cycles (address phase, then data phase). No address/data overlap.
- Zero wait states, AES handshakes accepted on first offer:
  - Per block: 8 read + 1 SEND + 1 RECV + 8 write = 18 cycles.
  - Job: `start` to `done` = 18·N + 1 cycles (the +1 covers FINISH).
- `busy` rises the cycle after `start` and falls with the `done` cycle.
- `start` arriving while `busy` is dropped. `start` arriving in the same cycle as `done` is also dropped.
- All address-phase outputs stay stable while `hready`=0.

## Test plan
- Single block: `size_data`=16, `src_addr`=0x100, `dst_addr`=0x200.
  - Memory returns 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - Expect `blk_out`=0x00112233_44556677_8899AABB_CCDDEEFF.
  - AES returns that block inverted; expect writes 0xFFEEDDCC... to 0x200, 0x204, 0x208, 0x20C.
  - Expect `done` 19 cycles after `start`.
- Three blocks, `size_data`=0x3F:
  - Expect reads from 0x100 through 0x12C and writes from 0x200 through 0x22C.
  - Expect exactly one `done`, at cycle 55.
- Wait states: hold `hready`=0 for 3 cycles on every phase.
  - Expect `haddr`/`htrans`/`hwdata` stable throughout, and correct data still written.
- Error: ERROR response on the third read.
  - Expect no write transfers, `done` with `error`=1, and `htrans`=IDLE on the second ERROR cycle.
  - A new `start` then clears `error`.
- Edge cases:
  - `size_data`=0x0F gives `done` with no bus traffic.
  - `start` while `busy` is ignored.
  - `hreset` asserted during RECV gives all outputs at reset values in the same cycle and no `done` pulse.
